// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared types and constants for the interrupt acknowledge path.
//   state_t      : acknowledge FSM states (IDLE, REQ, ACK1, ACK2)
//   lsb_t        : result of a lowest-set-bit search (found flag + index)
//   NUM_LEVELS   : number of IR levels (fixed at 8)
//   SPURIOUS_LVL : level reported for an acknowledge with no valid request
//   lowest_set() : index of the lowest set bit of an 8-bit vector
// -----------------------------------------------------------------------------
package pic_pkg;

  localparam int         NUM_LEVELS   = 8;
  localparam logic [2:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2,
    ACK2 = 2'd3
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } lsb_t;

  // Scans from the top down so the last hit is the lowest index (IR0 wins).
  function automatic lsb_t lowest_set(input logic [7:0] v);
    lsb_t r;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// -----------------------------------------------------------------------------
// pic_prio_enc
// 8-bit fixed-priority encoder, bit 0 highest priority.
//   vec   in  8  request vector
//   idx   out 3  index of the lowest set bit (0 when vec is zero)
//   valid out 1  vec has at least one bit set
// -----------------------------------------------------------------------------
module pic_prio_enc (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       valid
);
  import pic_pkg::*;

  lsb_t r;

  assign r     = lowest_set(vec);
  assign idx   = r.idx;
  assign valid = r.found;

endmodule

// File: rtl/inta_ack_ctrl.sv
// -----------------------------------------------------------------------------
// inta_ack_ctrl
// CPU-facing end of the interrupt path: picks the highest-priority pending,
// unmasked request, raises int_out, runs the two-pulse INTA handshake, sets
// the in-service bit, clears the request register, drives the vector byte and
// retires in-service bits on EOI commands.
//
// Ports:
//   clk          in  1  system clock
//   rst          in  1  synchronous, active-low reset
//   irr_in       in  8  pending requests from the request register
//   imr          in  8  mask register (1 = masked)
//   icw2_base    in  5  vector base T7..T3
//   inta_n       in  1  CPU acknowledge, active-low, asynchronous
//   eoi_req      in  1  one-cycle EOI strobe
//   eoi_specific in  1  1 = specific EOI, 0 = non-specific
//   eoi_level    in  3  level cleared by a specific EOI
//   aeoi         in  1  auto-EOI enable (only when AUTO_EOI_EN is defined)
//   int_out      out 1  interrupt request to the CPU
//   irr_clr      out 8  one-hot, one-cycle clear to the request register
//   isr_out      out 8  in-service register
//   data_out     out 8  vector byte {icw2_base, level}
//   data_oe      out 1  vector valid / bus drive enable
//
// Build option: define AUTO_EOI_EN to add the aeoi input; with aeoi=1 the
// in-service bit set by an acknowledge is dropped on the INTA rise ending it.
// -----------------------------------------------------------------------------
module inta_ack_ctrl #(
  parameter int INTA_SYNC_STAGES = 2,
  parameter int NUM_LEVELS       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irr_in,
  input  logic [7:0] imr,
  input  logic [4:0] icw2_base,
  input  logic       inta_n,
  input  logic       eoi_req,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
`ifdef AUTO_EOI_EN
  input  logic       aeoi,
`endif
  output logic       int_out,
  output logic [7:0] irr_clr,
  output logic [7:0] isr_out,
  output logic [7:0] data_out,
  output logic       data_oe
);
  import pic_pkg::*;

  if (NUM_LEVELS != pic_pkg::NUM_LEVELS) begin : g_bad_levels
    $error("inta_ack_ctrl: NUM_LEVELS must be 8");
  end
  if (INTA_SYNC_STAGES < 2) begin : g_bad_sync
    $error("inta_ack_ctrl: INTA_SYNC_STAGES must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // inta_n synchronizer and edge detect. Flops reset to 1 (bus idle) so that
  // leaving reset never fakes an edge.
  // ---------------------------------------------------------------------------
  logic [INTA_SYNC_STAGES-1:0] inta_sync;
  logic                        inta_prev;
  logic                        inta_s;
  logic                        inta_fall;
  logic                        inta_rise;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inta_sync <= '1;
      inta_prev <= 1'b1;
    end else begin
      inta_sync <= {inta_sync[INTA_SYNC_STAGES-2:0], inta_n};
      inta_prev <= inta_s;
    end
  end

  assign inta_s    = inta_sync[INTA_SYNC_STAGES-1];
  assign inta_fall = inta_prev & ~inta_s;
  assign inta_rise = ~inta_prev & inta_s;

  // ---------------------------------------------------------------------------
  // Priority resolution against the current in-service set.
  // ---------------------------------------------------------------------------
  logic [7:0] pending;
  logic [2:0] cand_idx, cur_idx;
  logic       cand_valid, cur_valid;
  logic       req_ok;

  assign pending = irr_in & ~imr;

  pic_prio_enc u_cand (.vec(pending), .idx(cand_idx), .valid(cand_valid));
  pic_prio_enc u_cur  (.vec(isr_out), .idx(cur_idx),  .valid(cur_valid));

  // A request may nest only above (lower index than) the level in service.
  assign req_ok = cand_valid && (!cur_valid || (cand_idx < cur_idx));

  // ---------------------------------------------------------------------------
  // Acknowledge FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_next;
  logic [2:0] lvl, lvl_next;
  logic [7:0] ack_set;
  logic [7:0] eoi_clr;
  logic [7:0] auto_clr;
  logic [7:0] isr_next;
`ifdef AUTO_EOI_EN
  // Distinguishes a real acknowledge from a spurious one, so auto-EOI never
  // drops an unrelated level-7 in-service bit.
  logic       lvl_real, lvl_real_next;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_next = state;
    lvl_next   = lvl;
    ack_set    = '0;
    auto_clr   = '0;
    int_out    = 1'b0;
    data_oe    = 1'b0;
    data_out   = '0;
`ifdef AUTO_EOI_EN
    lvl_real_next = lvl_real;
`endif
    unique case (state)
      IDLE: begin
        if (req_ok) state_next = REQ;
      end
      REQ: begin
        int_out = 1'b1;
        if (inta_fall) begin
          state_next = ACK1;
          // The level is frozen here; later irr_in changes cannot move it.
          if (req_ok) begin
            lvl_next = cand_idx;
            ack_set  = 8'b1 << cand_idx;
`ifdef AUTO_EOI_EN
            lvl_real_next = 1'b1;
`endif
          end else begin
            lvl_next = SPURIOUS_LVL;
`ifdef AUTO_EOI_EN
            lvl_real_next = 1'b0;
`endif
          end
        end else if (!req_ok) begin
          state_next = IDLE;
        end
      end
      ACK1: begin
        // First pulse: bus stays undriven; its trailing rise is ignored.
        if (inta_fall) state_next = ACK2;
      end
      ACK2: begin
        if (!inta_s) begin
          data_oe  = 1'b1;
          data_out = {icw2_base, lvl};
        end
        if (inta_rise) begin
          state_next = IDLE;
`ifdef AUTO_EOI_EN
          if (aeoi && lvl_real) auto_clr = 8'b1 << lvl;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    eoi_clr = '0;
    if (eoi_req) begin
      if (eoi_specific)   eoi_clr = 8'b1 << eoi_level;
      else if (cur_valid) eoi_clr = 8'b1 << cur_idx;
    end
  end

  // Set wins over clear on the same bit.
  assign isr_next = (isr_out & ~(eoi_clr | auto_clr)) | ack_set;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      lvl     <= '0;
      isr_out <= '0;
      irr_clr <= '0;
    end else begin
      state   <= state_next;
      lvl     <= lvl_next;
      isr_out <= isr_next;
      irr_clr <= ack_set;
    end
  end

`ifdef AUTO_EOI_EN
  always_ff @(posedge clk) begin
    if (!rst) lvl_real <= 1'b0;
    else      lvl_real <= lvl_real_next;
  end
`endif

endmodule

// File: tb/tb_inta_ack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inta_ack_ctrl
// Directed, self-checking bench for inta_ack_ctrl. Expected vector bytes are
// queued when an acknowledge is started and compared when data_oe appears.
// Define AUTO_EOI_EN to also exercise the auto-EOI option.
// -----------------------------------------------------------------------------
module tb_inta_ack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irr_in;
  logic [7:0] imr;
  logic [4:0] icw2_base;
  logic       inta_n;
  logic       eoi_req;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       aeoi;
  logic       int_out;
  logic [7:0] irr_clr;
  logic [7:0] isr_out;
  logic [7:0] data_out;
  logic       data_oe;

  int total = 0;
  int bad   = 0;
  logic [7:0] vec_q[$];

  always #5 clk = ~clk;

  inta_ack_ctrl #(.INTA_SYNC_STAGES(2), .NUM_LEVELS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .irr_in       (irr_in),
    .imr          (imr),
    .icw2_base    (icw2_base),
    .inta_n       (inta_n),
    .eoi_req      (eoi_req),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
`ifdef AUTO_EOI_EN
    .aeoi         (aeoi),
`endif
    .int_out      (int_out),
    .irr_clr      (irr_clr),
    .isr_out      (isr_out),
    .data_out     (data_out),
    .data_oe      (data_oe)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
    total++;
    assert (obs === want)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // First INTA pulse. With kill=1 the request vanishes on the cycle the
  // synchronized fall is seen, making the acknowledge spurious.
  task automatic pulse1(input logic [7:0] exp_clr, input logic [7:0] exp_isr, input bit kill);
    inta_n = 1'b0;
    step();
    step();
    if (kill) irr_in = 8'h00;
    step();
    check("ack1_irr_clr", irr_clr, exp_clr);
    check("ack1_isr", isr_out, exp_isr);
    check("ack1_int_out", {7'd0, int_out}, 8'h00);
    check("ack1_data_oe", {7'd0, data_oe}, 8'h00);
    irr_in = irr_in & ~exp_clr;   // request register honours the clear
    step();
    check("irr_clr_one_cycle", irr_clr, 8'h00);
    inta_n = 1'b1;
    step();
    step();
    step();
    check("ack1_rise_no_drive", {7'd0, data_oe}, 8'h00);
  endtask

  task automatic pulse2_fall(input logic [7:0] vec);
    logic [7:0] want;
    bit seen;
    vec_q.push_back(vec);
    inta_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (data_oe) seen = 1;
    end
    want = vec_q.pop_front();
    if (!seen) check("vec_timeout", {7'd0, data_oe}, 8'h01);
    else       check("vector", data_out, want);
  endtask

  task automatic pulse2_rise();
    inta_n = 1'b1;
    step();
    step();
    check("rise_data_oe", {7'd0, data_oe}, 8'h00);
    check("rise_data_out", data_out, 8'h00);
    step();
  endtask

  task automatic send_eoi(input bit specific, input logic [2:0] level);
    eoi_req      = 1'b1;
    eoi_specific = specific;
    eoi_level    = level;
    step();
    eoi_req      = 1'b0;
  endtask

  initial begin
    rst = 1'b0; irr_in = '0; imr = '0; icw2_base = 5'h08; inta_n = 1'b1;
    eoi_req = 1'b0; eoi_specific = 1'b0; eoi_level = '0; aeoi = 1'b0;

    // Reset state
    step();
    step();
    check("rst_int_out", {7'd0, int_out}, 8'h00);
    check("rst_irr_clr", irr_clr, 8'h00);
    check("rst_isr", isr_out, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_oe", {7'd0, data_oe}, 8'h00);
    rst = 1'b1;
    step();

    // Basic acknowledge of IR2
    irr_in = 8'h04;
    step();
    check("basic_int_out", {7'd0, int_out}, 8'h01);
    pulse1(8'h04, 8'h04, 0);
    pulse2_fall(8'h42);
    pulse2_rise();
    send_eoi(0, 3'd0);
    check("basic_eoi_isr", isr_out, 8'h00);

    // Priority with mask: IR1 masked, IR3 wins
    irr_in = 8'h0A; imr = 8'h02;
    step();
    check("prio_int_out", {7'd0, int_out}, 8'h01);
    pulse1(8'h08, 8'h08, 0);
    pulse2_fall(8'h43);
    pulse2_rise();

    // Nesting: IR0 preempts IR3 in service, IR4 does not
    irr_in = 8'h01; imr = 8'h00;
    step();
    check("nest_ir0_int_out", {7'd0, int_out}, 8'h01);
    irr_in = 8'h10;
    step();
    check("nest_ir4_drop", {7'd0, int_out}, 8'h00);
    step();
    check("nest_ir4_blocked", {7'd0, int_out}, 8'h00);
    send_eoi(0, 3'd0);
    check("nest_eoi_isr", isr_out, 8'h00);
    step();
    check("nest_ir4_int_out", {7'd0, int_out}, 8'h01);
    pulse1(8'h10, 8'h10, 0);
    pulse2_fall(8'h44);
    pulse2_rise();
    send_eoi(1, 3'd4);
    check("specific_eoi_isr", isr_out, 8'h00);

    // Request withdrawn before INTA
    irr_in = 8'h20;
    step();
    check("withdraw_int_up", {7'd0, int_out}, 8'h01);
    irr_in = 8'h00;
    step();
    check("withdraw_int_down", {7'd0, int_out}, 8'h00);

    // Request withdrawn exactly at the first INTA fall: spurious vector
    irr_in = 8'h20;
    step();
    check("spur_int_out", {7'd0, int_out}, 8'h01);
    pulse1(8'h00, 8'h00, 1);
    pulse2_fall(8'h47);
    pulse2_rise();
    check("spur_isr", isr_out, 8'h00);

    // Reset in the middle of ACK2
    irr_in = 8'h04;
    step();
    pulse1(8'h04, 8'h04, 0);
    pulse2_fall(8'h42);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_data_oe", {7'd0, data_oe}, 8'h00);
    check("midrst_isr", isr_out, 8'h00);
    check("midrst_int_out", {7'd0, int_out}, 8'h00);
    check("midrst_data_out", data_out, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_no_drive", {7'd0, data_oe}, 8'h00);
    end
    inta_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    inta_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_ignored", {6'd0, data_oe, int_out}, 8'h00);
    end
    check("post_rst_isr", isr_out, 8'h00);
    inta_n = 1'b1;
    for (int i = 0; i < 4; i++) step();

`ifdef AUTO_EOI_EN
    // Auto-EOI: IR5 bit retires the cycle after the second INTA rise
    aeoi = 1'b1;
    irr_in = 8'h20;
    step();
    check("aeoi_int_out", {7'd0, int_out}, 8'h01);
    pulse1(8'h20, 8'h20, 0);
    pulse2_fall(8'h45);
    check("aeoi_isr_ack2", isr_out, 8'h20);
    inta_n = 1'b1;
    step();
    step();
    check("aeoi_rise_data_oe", {7'd0, data_oe}, 8'h00);
    check("aeoi_isr_at_rise", isr_out, 8'h20);
    step();
    check("aeoi_isr_cleared", isr_out, 8'h00);
    aeoi = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the run always ends even if a wait is mis-sized.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
